// File: rtl/plab5_mcore_proc_resp_acc_buf.sv
// Buffered multi-level access-control stage between the memory-response network and one core.
// Define PLAB5_MCORE_PROC_RESP_ACC_SCRUB_EN to scrub denied responses instead of dropping them.
module plab5_mcore_proc_resp_acc_buf #(
  parameter int p_opaque_nbits = 8,
  parameter int p_data_nbits   = 32,
  parameter int p_level_nbits  = 2,
  parameter int p_num_entries  = 2,
  parameter int p_cnt_nbits    = 16,
  localparam int resp_nbits    = 3 + p_opaque_nbits + 2 + $clog2(p_data_nbits/8) + p_data_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [p_level_nbits-1:0] proc_sec_level,
  input  logic                     net_resp_val,
  output logic                     net_resp_rdy,
  input  logic [resp_nbits-1:0]    net_resp_msg,
  input  logic [p_level_nbits-1:0] net_resp_level,
  output logic                     proc_resp_val,
  input  logic                     proc_resp_rdy,
  output logic [resp_nbits-1:0]    proc_resp_msg,
  input  logic                     viol_clear,
  output logic [p_cnt_nbits-1:0]   viol_count,
  output logic                     viol_pulse
);

  localparam int ptr_nbits   = $clog2(p_num_entries);
  localparam int entry_nbits = p_level_nbits + resp_nbits;

  logic [entry_nbits-1:0]   mem_r [p_num_entries];
  logic [ptr_nbits-1:0]     wr_ptr_r;
  logic [ptr_nbits-1:0]     rd_ptr_r;
  logic [ptr_nbits:0]       count_r;
  logic [p_cnt_nbits-1:0]   viol_count_r;

  logic                     empty_s;
  logic                     full_s;
  logic                     enq_s;
  logic                     deq_s;
  logic                     allow_s;
  logic [p_level_nbits-1:0] head_level_s;
  logic [resp_nbits-1:0]    head_msg_s;

  assign empty_s      = (count_r == (ptr_nbits+1)'(0));
  assign full_s       = (count_r == (ptr_nbits+1)'(p_num_entries));
  assign net_resp_rdy = !reset && !full_s;
  assign enq_s        = net_resp_val && net_resp_rdy;
  assign head_level_s = mem_r[rd_ptr_r][entry_nbits-1:resp_nbits];
  assign head_msg_s   = mem_r[rd_ptr_r][resp_nbits-1:0];
  // Judged against the level in force this cycle, not the level at enqueue.
  assign allow_s      = (head_level_s <= proc_sec_level);
  assign viol_count   = viol_count_r;

  // Head presentation, dequeue decision and denial strobe.
  always_comb begin
    proc_resp_val = 1'b0;
    proc_resp_msg = '0;
    deq_s         = 1'b0;
    viol_pulse    = 1'b0;
    if (empty_s) begin
      deq_s = 1'b0;
    end else if (allow_s) begin
      proc_resp_val = 1'b1;
      proc_resp_msg = head_msg_s;
      deq_s         = proc_resp_rdy;
    end else begin
`ifdef PLAB5_MCORE_PROC_RESP_ACC_SCRUB_EN
      proc_resp_val = 1'b1;
      proc_resp_msg = {head_msg_s[resp_nbits-1:p_data_nbits], {p_data_nbits{1'b0}}};
      deq_s         = proc_resp_rdy;
      viol_pulse    = proc_resp_rdy;
`else
      deq_s         = 1'b1;
      viol_pulse    = 1'b1;
`endif
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (enq_s) begin
        mem_r[wr_ptr_r] <= {net_resp_level, net_resp_msg};
        wr_ptr_r        <= wr_ptr_r + ptr_nbits'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_nbits'(1);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + (ptr_nbits+1)'(1);
        2'b01:   count_r <= count_r - (ptr_nbits+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating violation counter; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_count_r <= '0;
    end else if (viol_clear) begin
      viol_count_r <= '0;
    end else if (viol_pulse && (viol_count_r != {p_cnt_nbits{1'b1}})) begin
      viol_count_r <= viol_count_r + p_cnt_nbits'(1);
    end else begin
      viol_count_r <= viol_count_r;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_proc_resp_acc_buf.sv
// Directed self-checking bench for plab5_mcore_proc_resp_acc_buf (4-bit violation counter instance).
module tb_plab5_mcore_proc_resp_acc_buf;

  localparam int RN = 47;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    proc_sec_level;
  logic          net_resp_val;
  logic          net_resp_rdy;
  logic [RN-1:0] net_resp_msg;
  logic [1:0]    net_resp_level;
  logic          proc_resp_val;
  logic          proc_resp_rdy;
  logic [RN-1:0] proc_resp_msg;
  logic          viol_clear;
  logic [3:0]    viol_count;
  logic          viol_pulse;

  int n_cmp = 0;
  int n_err = 0;

  logic [RN-1:0] m_a, m_b, m_c, m_d;

  plab5_mcore_proc_resp_acc_buf #(.p_cnt_nbits(4)) dut (
    .clk(clk), .reset(reset), .proc_sec_level(proc_sec_level),
    .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
    .net_resp_msg(net_resp_msg), .net_resp_level(net_resp_level),
    .proc_resp_val(proc_resp_val), .proc_resp_rdy(proc_resp_rdy),
    .proc_resp_msg(proc_resp_msg), .viol_clear(viol_clear),
    .viol_count(viol_count), .viol_pulse(viol_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RN-1:0] mk(input logic [7:0] opq, input logic [31:0] data);
    return {3'd1, opq, 2'd0, 2'd0, data};
  endfunction

  initial begin
    reset = 1'b1; proc_sec_level = 2'd0; net_resp_val = 1'b0; net_resp_msg = '0;
    net_resp_level = 2'd0; proc_resp_rdy = 1'b0; viol_clear = 1'b0;
    m_a = mk(8'h11, 32'hCAFEF00D);
    m_b = mk(8'h5A, 32'hDEADBEEF);
    #1;
    chk("rst_net_rdy", 64'(net_resp_rdy), 64'd0);
    chk("rst_val", 64'(proc_resp_val), 64'd0);
    chk("rst_msg", 64'(proc_resp_msg), 64'd0);
    chk("rst_cnt", 64'(viol_count), 64'd0);
    chk("rst_pulse", 64'(viol_pulse), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_rst_net_rdy", 64'(net_resp_rdy), 64'd1);

    // Pass: delivered one cycle after enqueue.
    proc_sec_level = 2'd2; proc_resp_rdy = 1'b1;
    net_resp_val = 1'b1; net_resp_msg = m_a; net_resp_level = 2'd1;
    #1;
    chk("pass_no_bypass", 64'(proc_resp_val), 64'd0);
    tick();
    net_resp_val = 1'b0;
    #1;
    chk("pass_val", 64'(proc_resp_val), 64'd1);
    chk("pass_msg", 64'(proc_resp_msg), 64'(m_a));
    chk("pass_pulse", 64'(viol_pulse), 64'd0);
    tick();
    chk("pass_drained", 64'(proc_resp_val), 64'd0);
    chk("pass_cnt", 64'(viol_count), 64'd0);

    // Deny.
    proc_sec_level = 2'd0; proc_resp_rdy = 1'b0;
    net_resp_val = 1'b1; net_resp_msg = m_b; net_resp_level = 2'd3;
    tick();
    net_resp_val = 1'b0;
    #1;
`ifdef PLAB5_MCORE_PROC_RESP_ACC_SCRUB_EN
    chk("scrub_val", 64'(proc_resp_val), 64'd1);
    chk("scrub_msg", 64'(proc_resp_msg), 64'({m_b[RN-1:32], 32'h0}));
    chk("scrub_no_pulse", 64'(viol_pulse), 64'd0);
    tick();
    chk("scrub_held", 64'(proc_resp_val), 64'd1);
    proc_resp_rdy = 1'b1;
    #1;
    chk("scrub_pulse", 64'(viol_pulse), 64'd1);
    tick();
`else
    chk("deny_val", 64'(proc_resp_val), 64'd0);
    chk("deny_msg", 64'(proc_resp_msg), 64'd0);
    chk("deny_pulse", 64'(viol_pulse), 64'd1);
    tick();
`endif
    chk("deny_pulse_gone", 64'(viol_pulse), 64'd0);
    chk("deny_val_after", 64'(proc_resp_val), 64'd0);
    chk("deny_cnt", 64'(viol_count), 64'd1);

    // Backpressure with depth 2.
    proc_sec_level = 2'd0; proc_resp_rdy = 1'b0;
    m_c = mk(8'h21, 32'h00000001);
    m_d = mk(8'h22, 32'h00000002);
    net_resp_level = 2'd0; net_resp_val = 1'b1; net_resp_msg = m_a;
    tick();
    net_resp_msg = m_c;
    tick();
    net_resp_msg = m_d;
    chk("bp_full_rdy", 64'(net_resp_rdy), 64'd0);
    tick();
    chk("bp_still_full", 64'(net_resp_rdy), 64'd0);
    proc_resp_rdy = 1'b1;
    #1;
    chk("bp_pop_no_rdy", 64'(net_resp_rdy), 64'd0);
    chk("bp_msg0", 64'(proc_resp_msg), 64'(m_a));
    tick();
    chk("bp_rdy_back", 64'(net_resp_rdy), 64'd1);
    chk("bp_msg1", 64'(proc_resp_msg), 64'(m_c));
    tick();
    net_resp_val = 1'b0;
    #1;
    chk("bp_msg2", 64'(proc_resp_msg), 64'(m_d));
    chk("bp_val2", 64'(proc_resp_val), 64'd1);
    tick();
    chk("bp_empty", 64'(proc_resp_val), 64'd0);

    // Clear the counter, then level change while queued.
    viol_clear = 1'b1;
    tick();
    viol_clear = 1'b0;
    chk("clear_cnt", 64'(viol_count), 64'd0);
    proc_sec_level = 2'd2; proc_resp_rdy = 1'b0;
    net_resp_level = 2'd2; net_resp_val = 1'b1; net_resp_msg = m_a;
    tick();
    net_resp_msg = m_c;
    tick();
    net_resp_val = 1'b0;
    #1;
    chk("lvl_allowed_head", 64'(proc_resp_val), 64'd1);
    proc_sec_level = 2'd1; proc_resp_rdy = 1'b1;
    #1;
    chk("lvl_pulse0", 64'(viol_pulse), 64'd1);
    tick();
    chk("lvl_pulse1", 64'(viol_pulse), 64'd1);
    tick();
    chk("lvl_pulse_end", 64'(viol_pulse), 64'd0);
    chk("lvl_cnt", 64'(viol_count), 64'd2);

    // Saturation: stream 16 denials into a 4-bit counter.
    proc_sec_level = 2'd0; proc_resp_rdy = 1'b1;
    net_resp_level = 2'd3; net_resp_msg = m_b; net_resp_val = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    net_resp_val = 1'b0;
    tick(); tick();
    chk("sat_cnt", 64'(viol_count), 64'hF);
    net_resp_val = 1'b1;
    tick();
    net_resp_val = 1'b0;
    #1;
    chk("sat_extra_pulse", 64'(viol_pulse), 64'd1);
    tick();
    chk("sat_hold", 64'(viol_count), 64'hF);
    net_resp_val = 1'b1;
    tick();
    net_resp_val = 1'b0;
    viol_clear = 1'b1;
    #1;
    chk("clr_conc_pulse", 64'(viol_pulse), 64'd1);
    tick();
    viol_clear = 1'b0;
    chk("clr_conc_cnt", 64'(viol_count), 64'd0);
    net_resp_val = 1'b1;
    tick();
    net_resp_val = 1'b0;
    tick();
    chk("cnt_after_clr", 64'(viol_count), 64'd1);

    // Reset mid-stream with two entries queued.
    proc_sec_level = 2'd3; proc_resp_rdy = 1'b0;
    net_resp_level = 2'd0; net_resp_msg = m_a; net_resp_val = 1'b1;
    tick();
    net_resp_msg = m_c;
    tick();
    net_resp_val = 1'b0;
    #1;
    chk("mid_val_before", 64'(proc_resp_val), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_val", 64'(proc_resp_val), 64'd0);
    chk("mid_rst_net_rdy", 64'(net_resp_rdy), 64'd0);
    chk("mid_rst_cnt", 64'(viol_count), 64'd0);
    tick();
    reset = 1'b0;
    proc_resp_rdy = 1'b1;
    #1;
    chk("mid_rel_net_rdy", 64'(net_resp_rdy), 64'd1);
    chk("mid_rel_val", 64'(proc_resp_val), 64'd0);
    tick();
    chk("mid_rel_empty", 64'(proc_resp_val), 64'd0);
    chk("mid_rel_cnt", 64'(viol_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
